// File: rtl/rx_data_unpack.sv
// Receive-side DATA-field unpacker: drops SERVICE, packs PSDU bytes, drops tail and pad to the symbol boundary.
// Optional RX_SERVICE_CHECK_EN adds service_err, flagging a non-zero descrambled SERVICE field.
module rx_data_unpack #(
  parameter bit          MSB_FIRST = 1'b1,
  parameter int unsigned MAX_LEN   = 4095
) (
  input  logic        clk_User,
  input  logic        reset,
  input  logic        start,
  input  logic [5:0]  rx_Rate,
  input  logic [15:0] packetlength,
  input  logic        data_bit_valid,
  input  logic        data_bit,
  output logic        recv_data_valid,
  output logic [7:0]  recv_data,
  output logic        recv_last,
  output logic        recv_done,
  output logic        busy,
  output logic        rx_err
`ifdef RX_SERVICE_CHECK_EN
  ,
  output logic        service_err
`endif
);

  localparam int unsigned CNT_W  = 4;
  localparam int unsigned BYTE_W = 8;
  localparam int unsigned LEN_W  = 16;
  localparam int unsigned SYM_W  = 8;

  typedef enum logic [2:0] {
    S_IDLE,
    S_SERVICE,
    S_DATA,
    S_TAIL,
    S_PAD,
    S_DONE
  } state_t;

  state_t             state, state_nxt;
  logic [SYM_W-1:0]   bps, bps_nxt;
  logic [LEN_W-1:0]   len, len_nxt;
  logic [LEN_W-1:0]   byte_cnt, byte_cnt_nxt;
  logic [CNT_W-1:0]   bit_cnt, bit_cnt_nxt;
  logic [SYM_W-1:0]   sym_cnt, sym_cnt_nxt;
  logic [BYTE_W-1:0]  shreg, shreg_nxt;
  logic [BYTE_W-1:0]  byte_full;
  logic               consume;
  logic               sym_wrap;
  logic               valid_nxt, last_nxt, done_nxt, busy_nxt, err_nxt;
  logic [BYTE_W-1:0]  data_nxt;
`ifdef RX_SERVICE_CHECK_EN
  logic               svc_seen, svc_seen_nxt, svc_err_nxt;
`endif

  // State and output registers
  always_ff @(posedge clk_User) begin
    if (reset) begin
      state           <= S_IDLE;
      bps             <= '0;
      len             <= '0;
      byte_cnt        <= '0;
      bit_cnt         <= '0;
      sym_cnt         <= '0;
      shreg           <= '0;
      recv_data_valid <= 1'b0;
      recv_data       <= '0;
      recv_last       <= 1'b0;
      recv_done       <= 1'b0;
      busy            <= 1'b0;
      rx_err          <= 1'b0;
`ifdef RX_SERVICE_CHECK_EN
      svc_seen        <= 1'b0;
      service_err     <= 1'b0;
`endif
    end else begin
      state           <= state_nxt;
      bps             <= bps_nxt;
      len             <= len_nxt;
      byte_cnt        <= byte_cnt_nxt;
      bit_cnt         <= bit_cnt_nxt;
      sym_cnt         <= sym_cnt_nxt;
      shreg           <= shreg_nxt;
      recv_data_valid <= valid_nxt;
      recv_data       <= data_nxt;
      recv_last       <= last_nxt;
      recv_done       <= done_nxt;
      busy            <= busy_nxt;
      rx_err          <= err_nxt;
`ifdef RX_SERVICE_CHECK_EN
      svc_seen        <= svc_seen_nxt;
      service_err     <= svc_err_nxt;
`endif
    end
  end

  // Next-state and next-output logic
  always_comb begin
    state_nxt    = state;
    bps_nxt      = bps;
    len_nxt      = len;
    byte_cnt_nxt = byte_cnt;
    bit_cnt_nxt  = bit_cnt;
    sym_cnt_nxt  = sym_cnt;
    shreg_nxt    = shreg;
    valid_nxt    = 1'b0;
    data_nxt     = recv_data;
    last_nxt     = 1'b0;
    done_nxt     = 1'b0;
    busy_nxt     = busy;
    err_nxt      = 1'b0;
`ifdef RX_SERVICE_CHECK_EN
    svc_seen_nxt = svc_seen;
    svc_err_nxt  = 1'b0;
`endif

    byte_full = MSB_FIRST ? {shreg[BYTE_W-2:0], data_bit} : {data_bit, shreg[BYTE_W-1:1]};
    consume   = data_bit_valid && (state inside {S_SERVICE, S_DATA, S_TAIL, S_PAD});
    sym_wrap  = (sym_cnt == bps - SYM_W'(1));

    // Symbol position runs over every consumed bit so the pad ends on a boundary
    if (consume) begin
      sym_cnt_nxt = sym_wrap ? '0 : sym_cnt + SYM_W'(1);
    end

    case (state)
      S_IDLE: begin
        if (start) begin
          if (rx_Rate == '0 || 32'(packetlength) > MAX_LEN) begin
            err_nxt = 1'b1;
          end else begin
            state_nxt    = S_SERVICE;
            bps_nxt      = {rx_Rate, 2'b00};
            len_nxt      = packetlength;
            byte_cnt_nxt = '0;
            bit_cnt_nxt  = '0;
            sym_cnt_nxt  = '0;
            busy_nxt     = 1'b1;
`ifdef RX_SERVICE_CHECK_EN
            svc_seen_nxt = 1'b0;
`endif
          end
        end
      end
      S_SERVICE: begin
        if (data_bit_valid) begin
          if (bit_cnt == CNT_W'(15)) begin
            bit_cnt_nxt = '0;
            state_nxt   = (len == '0) ? S_TAIL : S_DATA;
`ifdef RX_SERVICE_CHECK_EN
            svc_err_nxt = svc_seen | data_bit;
`endif
          end else begin
            bit_cnt_nxt = bit_cnt + CNT_W'(1);
`ifdef RX_SERVICE_CHECK_EN
            svc_seen_nxt = svc_seen | data_bit;
`endif
          end
        end
      end
      S_DATA: begin
        if (data_bit_valid) begin
          shreg_nxt = byte_full;
          if (bit_cnt == CNT_W'(7)) begin
            bit_cnt_nxt  = '0;
            valid_nxt    = 1'b1;
            data_nxt     = byte_full;
            byte_cnt_nxt = byte_cnt + LEN_W'(1);
            if (byte_cnt + LEN_W'(1) == len) begin
              last_nxt  = 1'b1;
              state_nxt = S_TAIL;
            end
          end else begin
            bit_cnt_nxt = bit_cnt + CNT_W'(1);
          end
        end
      end
      S_TAIL: begin
        if (data_bit_valid) begin
          if (bit_cnt == CNT_W'(5)) begin
            bit_cnt_nxt = '0;
            // Tail ending exactly on a symbol boundary means there is no pad
            if (sym_wrap) begin
              state_nxt = S_DONE;
              done_nxt  = 1'b1;
              busy_nxt  = 1'b0;
            end else begin
              state_nxt = S_PAD;
            end
          end else begin
            bit_cnt_nxt = bit_cnt + CNT_W'(1);
          end
        end
      end
      S_PAD: begin
        if (sym_cnt == '0 || (data_bit_valid && sym_wrap)) begin
          state_nxt = S_DONE;
          done_nxt  = 1'b1;
          busy_nxt  = 1'b0;
        end
      end
      S_DONE: begin
        state_nxt = S_IDLE;
      end
      default: begin
        state_nxt = S_IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_rx_data_unpack.sv
// Randomized self-checking bench for rx_data_unpack; expected bytes and timing come from a bit-list frame model.
module tb_rx_data_unpack;

  localparam bit          MSB_FIRST = 1'b1;
  localparam int unsigned MAX_LEN   = 4095;

  logic        clk_User = 1'b0;
  logic        reset;
  logic        start;
  logic [5:0]  rx_Rate;
  logic [15:0] packetlength;
  logic        data_bit_valid;
  logic        data_bit;
  logic        recv_data_valid;
  logic [7:0]  recv_data;
  logic        recv_last;
  logic        recv_done;
  logic        busy;
  logic        rx_err;
`ifdef RX_SERVICE_CHECK_EN
  logic        service_err;
`endif

  rx_data_unpack #(.MSB_FIRST(MSB_FIRST), .MAX_LEN(MAX_LEN)) dut (
    .clk_User        (clk_User),
    .reset           (reset),
    .start           (start),
    .rx_Rate         (rx_Rate),
    .packetlength    (packetlength),
    .data_bit_valid  (data_bit_valid),
    .data_bit        (data_bit),
    .recv_data_valid (recv_data_valid),
    .recv_data       (recv_data),
    .recv_last       (recv_last),
    .recv_done       (recv_done),
    .busy            (busy),
    .rx_err          (rx_err)
`ifdef RX_SERVICE_CHECK_EN
    ,
    .service_err     (service_err)
`endif
  );

  always #5 clk_User = ~clk_User;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;
  always @(posedge clk_User) cyc <= cyc + 1;

  // Observed traffic, stamped with the cycle count at which it was seen
  logic [7:0] mon_data[$];
  bit         mon_last[$];
  int         mon_cyc[$];
  int         done_cyc[$];
  int         svc_cyc[$];
  int         err_pulses = 0;

  always @(negedge clk_User) begin
    if (recv_data_valid) begin
      mon_data.push_back(recv_data);
      mon_last.push_back(recv_last);
      mon_cyc.push_back(cyc);
    end
    if (recv_done) done_cyc.push_back(cyc);
    if (rx_err) err_pulses++;
`ifdef RX_SERVICE_CHECK_EN
    if (service_err) svc_cyc.push_back(cyc);
`endif
  end

  // Frame model: the full bit list for a frame and the cycle each bit was offered
  logic [7:0] exp_bytes[$];
  bit         bitq[$];
  int         bit_cyc[$];
  int         total_bits;

  task automatic clear_mon();
    mon_data.delete(); mon_last.delete(); mon_cyc.delete();
    done_cyc.delete(); svc_cyc.delete();
  endtask

  task automatic build_bits(input int rate, input int svc_one);
    int bps;
    bps = rate * 4;
    bitq.delete();
    bit_cyc.delete();
    for (int i = 0; i < 16; i++) bitq.push_back(i == svc_one);
    foreach (exp_bytes[k])
      for (int b = 0; b < 8; b++) bitq.push_back(MSB_FIRST ? exp_bytes[k][7-b] : exp_bytes[k][b]);
    repeat (6) bitq.push_back(1'b0);
    total_bits = ((22 + 8 * exp_bytes.size() + bps - 1) / bps) * bps;
    while (bitq.size() < total_bits) bitq.push_back(1'($urandom_range(0, 1)));
  endtask

  task automatic pulse_start(input int rate, input int len, input logic sim_bit);
    @(negedge clk_User);
    start = 1'b1; rx_Rate = 6'(rate); packetlength = 16'(len);
    data_bit_valid = sim_bit; data_bit = 1'b1;
    @(negedge clk_User);
    start = 1'b0; data_bit_valid = 1'b0; data_bit = 1'b0;
  endtask

  task automatic drive_bits(input int from, input int to, input int gap_pct);
    for (int i = from; i < to; i++) begin
      @(negedge clk_User);
      while (int'($urandom_range(0, 99)) < gap_pct) begin
        data_bit_valid = 1'b0; data_bit = 1'($urandom);
        @(negedge clk_User);
      end
      data_bit_valid = 1'b1; data_bit = bitq[i];
      bit_cyc.push_back(cyc);
    end
  endtask

  task automatic wait_done(input int budget, output bit seen);
    seen = 1'b0;
    for (int i = 0; i < budget && !seen; i++) begin
      @(negedge clk_User);
      data_bit_valid = 1'b0;
      #1;
      if (done_cyc.size() != 0) seen = 1'b1;
    end
    repeat (3) @(negedge clk_User);
  endtask

  task automatic test_reset();
    reset = 1'b1; start = 1'b0; rx_Rate = '0; packetlength = '0;
    data_bit_valid = 1'b0; data_bit = 1'b0;
    repeat (3) @(negedge clk_User);
    checks++;
    if ({recv_data_valid, recv_data, recv_last, recv_done, busy, rx_err} !== 13'd0) begin
      errors++; $display("FAIL reset_outputs got %b want 0", {recv_data_valid, recv_data, recv_last, recv_done, busy, rx_err});
    end
    reset = 1'b0;
    repeat (2) @(negedge clk_User);
    checks++;
    if ({recv_data_valid, recv_done, busy, rx_err} !== 4'd0) begin
      errors++; $display("FAIL idle_outputs got %b want 0", {recv_data_valid, recv_done, busy, rx_err});
    end
  endtask

  task automatic test_single();
    bit seen;
    clear_mon();
    exp_bytes.delete(); exp_bytes.push_back(8'hA5);
    build_bits(6, -1);
    pulse_start(6, 1, 1'b0);
    checks++;
    if (busy !== 1'b1) begin errors++; $display("FAIL single_busy got %b want 1", busy); end
    drive_bits(0, total_bits, 0);
    wait_done(20, seen);
    checks++;
    if (mon_data.size() != 1 || mon_data[0] !== 8'hA5 || mon_last[0] !== 1'b1 || mon_cyc[0] != bit_cyc[23] + 1) begin
      errors++; $display("FAIL single_byte got n=%0d want one A5 last at cyc %0d", mon_data.size(), bit_cyc[23] + 1);
    end
    checks++;
    if (!seen || done_cyc.size() != 1 || done_cyc[0] != bit_cyc[47] + 1) begin
      errors++; $display("FAIL single_done got n=%0d want one at cyc %0d", done_cyc.size(), bit_cyc[47] + 1);
    end
    checks++;
    if (busy !== 1'b0) begin errors++; $display("FAIL single_busy_after got %b want 0", busy); end
`ifdef RX_SERVICE_CHECK_EN
    checks++;
    if (svc_cyc.size() != 0) begin errors++; $display("FAIL single_svc got %0d pulses want 0", svc_cyc.size()); end
`endif
  endtask

  task automatic test_long();
    bit seen;
    clear_mon();
    exp_bytes.delete();
    for (int k = 0; k < 100; k++) exp_bytes.push_back(8'(k));
    build_bits(54, -1);
    pulse_start(54, 100, 1'b0);
    drive_bits(0, total_bits, 40);
    wait_done(20, seen);
    checks++;
    if (mon_data.size() != exp_bytes.size()) begin
      errors++; $display("FAIL long_count got %0d want %0d", mon_data.size(), exp_bytes.size());
    end
    for (int k = 0; k < exp_bytes.size() && k < mon_data.size(); k++) begin
      checks++;
      if (mon_data[k] !== exp_bytes[k] || mon_last[k] !== (k == exp_bytes.size() - 1) || mon_cyc[k] != bit_cyc[23 + 8 * k] + 1) begin
        errors++; $display("FAIL long_byte%0d got %h/%b@%0d want %h/%b@%0d", k, mon_data[k], mon_last[k], mon_cyc[k],
                           exp_bytes[k], (k == exp_bytes.size() - 1), bit_cyc[23 + 8 * k] + 1);
      end
    end
    checks++;
    if (!seen || done_cyc.size() != 1 || done_cyc[0] != bit_cyc[863] + 1) begin
      errors++; $display("FAIL long_done got n=%0d want one at cyc %0d (bit 864)", done_cyc.size(), bit_cyc[863] + 1);
    end
  endtask

  task automatic test_zero_len();
    bit seen;
    clear_mon();
    exp_bytes.delete();
    build_bits(6, -1);
    pulse_start(6, 0, 1'b0);
    drive_bits(0, total_bits, 25);
    wait_done(20, seen);
    checks++;
    if (mon_data.size() != 0) begin errors++; $display("FAIL zero_bytes got %0d want 0", mon_data.size()); end
    checks++;
    if (!seen || done_cyc.size() != 1 || done_cyc[0] != bit_cyc[23] + 1) begin
      errors++; $display("FAIL zero_done got n=%0d want one at cyc %0d (bit 24)", done_cyc.size(), bit_cyc[23] + 1);
    end
  endtask

  task automatic test_errors();
    bit seen;
    bit busy_seen;
    int rate_q[3] = '{0, 6, 6};
    int len_q[3]  = '{10, 5000, MAX_LEN + 1};
    clear_mon();
    err_pulses = 0;
    for (int i = 0; i < 3; i++) begin
      pulse_start(rate_q[i], len_q[i], 1'b0);
      busy_seen = 1'b0;
      repeat (3) begin
        @(negedge clk_User); #1;
        if (busy) busy_seen = 1'b1;
      end
      checks++;
      if (err_pulses != i + 1 || busy_seen) begin
        errors++; $display("FAIL reject%0d got err=%0d busy=%b want err=%0d busy=0", i, err_pulses, busy_seen, i + 1);
      end
    end
    // Largest legal length is accepted; abort it with reset
    pulse_start(6, MAX_LEN, 1'b0);
    @(negedge clk_User); #1;
    checks++;
    if (busy !== 1'b1 || err_pulses != 3) begin
      errors++; $display("FAIL accept_max got busy=%b err=%0d want 1/3", busy, err_pulses);
    end
    reset = 1'b1;
    @(negedge clk_User);
    reset = 1'b0;
    // Starts during a running frame are ignored
    exp_bytes.delete();
    repeat (2) exp_bytes.push_back(8'($urandom));
    build_bits(6, -1);
    pulse_start(6, 2, 1'b0);
    drive_bits(0, 10, 20);
    pulse_start(0, 5000, 1'b0);
    pulse_start(9, 1, 1'b0);
    drive_bits(10, total_bits, 20);
    wait_done(20, seen);
    checks++;
    if (err_pulses != 3) begin errors++; $display("FAIL busy_start_err got %0d want 3", err_pulses); end
    checks++;
    if (mon_data.size() != 2 || mon_data[0] !== exp_bytes[0] || mon_data[1] !== exp_bytes[1] || mon_last[1] !== 1'b1) begin
      errors++; $display("FAIL busy_start_bytes got n=%0d want %h %h", mon_data.size(), exp_bytes[0], exp_bytes[1]);
    end
    checks++;
    if (!seen || done_cyc.size() != 1 || done_cyc[0] != bit_cyc[total_bits - 1] + 1) begin
      errors++; $display("FAIL busy_start_done got n=%0d want one at cyc %0d", done_cyc.size(), bit_cyc[total_bits - 1] + 1);
    end
  endtask

  task automatic test_reset_mid();
    bit seen;
    clear_mon();
    exp_bytes.delete();
    repeat (3) exp_bytes.push_back(8'($urandom));
    build_bits(6, -1);
    pulse_start(6, 3, 1'b0);
    drive_bits(0, 36, 0);
    @(negedge clk_User);
    data_bit_valid = 1'b0; reset = 1'b1;
    @(negedge clk_User);
    reset = 1'b0;
    #1;
    checks++;
    if ({recv_data_valid, recv_last, recv_done, busy, rx_err} !== 5'd0 || recv_data !== 8'd0) begin
      errors++; $display("FAIL midreset_outputs got %b/%h want 0", {recv_data_valid, recv_last, recv_done, busy, rx_err}, recv_data);
    end
    repeat (3) @(negedge clk_User);
    checks++;
    if (done_cyc.size() != 0) begin errors++; $display("FAIL midreset_done got %0d want 0", done_cyc.size()); end
    clear_mon();
    exp_bytes.delete(); exp_bytes.push_back(8'h3C); exp_bytes.push_back(8'hC3);
    build_bits(12, -1);
    pulse_start(12, 2, 1'b1);
    drive_bits(0, total_bits, 30);
    wait_done(20, seen);
    checks++;
    if (mon_data.size() != 2 || mon_data[0] !== 8'h3C || mon_data[1] !== 8'hC3 || mon_last[0] !== 1'b0 || mon_last[1] !== 1'b1) begin
      errors++; $display("FAIL after_reset_bytes got n=%0d want 3C C3", mon_data.size());
    end
    checks++;
    if (!seen || done_cyc.size() != 1 || done_cyc[0] != bit_cyc[47] + 1) begin
      errors++; $display("FAIL after_reset_done got n=%0d want one at cyc %0d (bit 48)", done_cyc.size(), bit_cyc[47] + 1);
    end
  endtask

  task automatic test_service();
    bit seen;
    clear_mon();
    exp_bytes.delete(); exp_bytes.push_back(8'h5A);
    build_bits(6, 5);
    pulse_start(6, 1, 1'b0);
    drive_bits(0, total_bits, 20);
    wait_done(20, seen);
    checks++;
    if (mon_data.size() != 1 || mon_data[0] !== 8'h5A || !seen) begin
      errors++; $display("FAIL service_bytes got n=%0d done=%b want one 5A and done", mon_data.size(), seen);
    end
`ifdef RX_SERVICE_CHECK_EN
    checks++;
    if (svc_cyc.size() != 1 || svc_cyc[0] != bit_cyc[15] + 1) begin
      errors++; $display("FAIL service_err got n=%0d want one at cyc %0d", svc_cyc.size(), bit_cyc[15] + 1);
    end
`endif
  endtask

  task automatic test_random();
    bit seen;
    int rate, len;
    for (int f = 0; f < 6; f++) begin
      rate = int'($urandom_range(1, 63));
      len  = int'($urandom_range(0, 30));
      clear_mon();
      exp_bytes.delete();
      for (int k = 0; k < len; k++) exp_bytes.push_back(8'($urandom));
      build_bits(rate, -1);
      pulse_start(rate, len, 1'($urandom));
      drive_bits(0, total_bits, 30);
      wait_done(20, seen);
      checks++;
      if (mon_data.size() != len) begin
        errors++; $display("FAIL rand%0d_count rate=%0d got %0d want %0d", f, rate, mon_data.size(), len);
      end
      for (int k = 0; k < len && k < mon_data.size(); k++) begin
        checks++;
        if (mon_data[k] !== exp_bytes[k] || mon_last[k] !== (k == len - 1) || mon_cyc[k] != bit_cyc[23 + 8 * k] + 1) begin
          errors++; $display("FAIL rand%0d_byte%0d got %h/%b@%0d want %h/%b@%0d", f, k, mon_data[k], mon_last[k], mon_cyc[k],
                             exp_bytes[k], (k == len - 1), bit_cyc[23 + 8 * k] + 1);
        end
      end
      checks++;
      if (!seen || done_cyc.size() != 1 || done_cyc[0] != bit_cyc[total_bits - 1] + 1) begin
        errors++; $display("FAIL rand%0d_done rate=%0d len=%0d got n=%0d want one at cyc %0d", f, rate, len,
                           done_cyc.size(), bit_cyc[total_bits - 1] + 1);
      end
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_long();
    test_zero_len();
    test_errors();
    test_reset_mid();
    test_service();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog expired at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

endmodule
